// File: rtl/sequential_multiplier_16bit_pkg.sv
// Shared constants for the 16x16 shift-add multiplier: state encoding and
// datapath geometry.
package sequential_multiplier_16bit_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_ITERS = 16;
  localparam int MUL_CNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/sequential_multiplier_16bit_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
interface sequential_multiplier_16bit_if;
  import sequential_multiplier_16bit_pkg::*;

  logic                       start;
  logic [MUL_WIDTH-1:0]       multiplicand;
  logic [MUL_WIDTH-1:0]       multiplier;
  logic                       busy;
  logic                       done;
  logic [2*MUL_WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/sequential_multiplier_16bit_adder.sv
// 16-bit carry-lookahead adder (4-bit lookahead groups) with a carry-out
// reconstructed from the operand and sum MSBs.
module adder_16bit_with_carry
  import sequential_multiplier_16bit_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a,
  input  logic [MUL_WIDTH-1:0] b,
  input  logic                 c_in,
  output logic [MUL_WIDTH-1:0] sum,
  output logic                 c_out
);

  logic [MUL_WIDTH-1:0] g_s;
  logic [MUL_WIDTH-1:0] p_s;
  logic [MUL_WIDTH-1:0] carry_s;
  logic [2:0]           grp_g_s;
  logic [2:0]           grp_p_s;
  logic [3:0]           grp_c_s;

  // Two-level lookahead: group generate/propagate, then per-bit carries
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    grp_g_s = 3'd0;
    grp_p_s = 3'd0;
    grp_c_s = 4'd0;
    carry_s = 16'd0;
    for (int k = 0; k < 3; k++) begin
      grp_g_s[k] = g_s[4*k+3]
                 | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      grp_p_s[k] = p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k];
    end
    grp_c_s[0] = c_in;
    for (int k = 0; k < 3; k++) begin
      grp_c_s[k+1] = grp_g_s[k] | (grp_p_s[k] & grp_c_s[k]);
    end
    for (int k = 0; k < 4; k++) begin
      carry_s[4*k]   = grp_c_s[k];
      carry_s[4*k+1] = g_s[4*k] | (p_s[4*k] & grp_c_s[k]);
      carry_s[4*k+2] = g_s[4*k+1]
                     | (p_s[4*k+1] & g_s[4*k])
                     | (p_s[4*k+1] & p_s[4*k] & grp_c_s[k]);
      carry_s[4*k+3] = g_s[4*k+2]
                     | (p_s[4*k+2] & g_s[4*k+1])
                     | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                     | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & grp_c_s[k]);
    end
  end

  assign sum = p_s ^ carry_s;

  // (a15&b15) | ((a15|b15)&~s15), written with g/p since a15|b15 == g15|p15
  assign c_out = g_s[MUL_WIDTH-1] | (p_s[MUL_WIDTH-1] & ~sum[MUL_WIDTH-1]);

endmodule

// File: rtl/sequential_multiplier_16bit.sv
// Unsigned 16x16 shift-add multiplier: one adder pass per cycle, 16 iterations,
// product held until the next accepted start.
module sequential_multiplier_16bit
  import sequential_multiplier_16bit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
)
(
  input  logic                          clk,
  input  logic                          reset,
  sequential_multiplier_16bit_if.slave  bus
);

  logic [1:0]         state_r;
  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   q_r;
  logic [CNT_W-1:0]   count_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  logic [WIDTH-1:0]   add_b_s;
  logic [WIDTH-1:0]   sum_s;
  logic               carry_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic [WIDTH-1:0]   q_next_s;
  logic               start_ok_s;
  logic               last_iter_s;

  // Partial-product addend: multiplicand when the current multiplier LSB is set
  always_comb begin
    add_b_s = 16'd0;
    if (q_r[0]) begin
      add_b_s = m_r;
    end else begin
      add_b_s = 16'd0;
    end
  end

  adder_16bit_with_carry u_adder (
    .a     (acc_r),
    .b     (add_b_s),
    .c_in  (1'b0),
    .sum   (sum_s),
    .c_out (carry_s)
  );

  // The 17-bit {c,s} shifts right as one unit across acc and q
  assign acc_next_s  = {carry_s, sum_s[WIDTH-1:1]};
  assign q_next_s    = {sum_s[0], q_r[WIDTH-1:1]};
  assign start_ok_s  = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign last_iter_s = (count_r == CNT_W'(MUL_ITERS - 1));

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      m_r       <= 16'd0;
      acc_r     <= 16'd0;
      q_r       <= 16'd0;
      count_r   <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            m_r     <= bus.multiplicand;
            q_r     <= bus.multiplier;
            acc_r   <= 16'd0;
            count_r <= {CNT_W{1'b0}};
            state_r <= CALC;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          q_r     <= q_next_s;
          count_r <= count_r + CNT_W'(1);
          if (last_iter_s) begin
            state_r   <= DONE;
            product_r <= {acc_next_s, q_next_s};
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r <= CALC;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_sequential_multiplier_16bit.sv
// Self-checking bench for sequential_multiplier_16bit: vector table, corner
// sequences and random operands, with a queue of expected products.
module tb_sequential_multiplier_16bit;

  logic clk;
  logic reset;

  sequential_multiplier_16bit_if bus();

  sequential_multiplier_16bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [7];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_prod;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Drive an accepted start; returns on the negedge right after the start edge
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called on the negedge after the start edge; waits (bounded) for done
  task automatic wait_done(input string name, input bit inject);
    int          n;
    int          busy_n;
    bit          stable;
    logic [31:0] exp;
    n      = 0;
    busy_n = 0;
    stable = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.product !== last_prod) stable = 1'b0;
      if (inject) begin
        bus.start        = (n == 3 || n == 9);
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd16);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd16);
    check({name, "_product_held"}, 32'(stable), 32'd1);
    check({name, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard: queue empty at done, product 0x%08h", name, bus.product);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_product"}, bus.product, exp);
      last_prod = exp;
    end
  endtask

  // One cycle after done: pulse over, back in IDLE, product still held
  task automatic after_done(input string name);
    @(negedge clk);
    check({name, "_done_width"}, 32'(bus.done), 32'd0);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_hold"}, bus.product, last_prod);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    bit          seen_done;

    vecs[0] = '{a: 16'd65000,  b: 16'd535,    exp: 32'h02129FD8};
    vecs[1] = '{a: 16'hFFFF,   b: 16'hFFFF,   exp: 32'hFFFE0001};
    vecs[2] = '{a: 16'h0000,   b: 16'h1234,   exp: 32'h00000000};
    vecs[3] = '{a: 16'h0001,   b: 16'h0001,   exp: 32'h00000001};
    vecs[4] = '{a: 16'h1234,   b: 16'h0000,   exp: 32'h00000000};
    vecs[5] = '{a: 16'h8000,   b: 16'h0002,   exp: 32'h00010000};
    vecs[6] = '{a: 16'hFFFF,   b: 16'h0001,   exp: 32'h0000FFFF};

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = 16'd0;
    bus.multiplier   = 16'd0;
    last_prod        = 32'd0;

    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", bus.product, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), 1'b0);
      after_done($sformatf("vec%0d", i));
    end

    // Start pulses and operand changes during CALC must be ignored
    launch(16'd7, 16'd6, 32'd42);
    wait_done("ignore_start", 1'b1);
    after_done("ignore_start");

    // Back-to-back: start held high through DONE
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 16'd3;
    bus.multiplier   = 16'd5;
    exp_q.push_back(32'd15);
    @(negedge clk);
    bus.multiplicand = 16'd100;
    bus.multiplier   = 16'd200;
    exp_q.push_back(32'd20000);
    wait_done("b2b_first", 1'b0);
    @(negedge clk);
    check("b2b_busy_restart", 32'(bus.busy), 32'd1);
    check("b2b_done_width", 32'(bus.done), 32'd0);
    check("b2b_product_held", bus.product, 32'd15);
    bus.start = 1'b0;
    wait_done("b2b_second", 1'b0);
    after_done("b2b_second");

    // Asynchronous reset in the middle of an operation
    launch(16'hABCD, 16'h1234, 32'h0C374FA4);
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", bus.product, 32'd0);
    exp_q.delete();
    last_prod = 32'd0;
    @(negedge clk);
    reset     = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    launch(16'd2, 16'd3, 32'd6);
    wait_done("after_abort", 1'b0);
    after_done("after_abort");

    // Random operands against a 32-bit reference product
    for (int r = 0; r < 1000; r++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      launch(ra, rb, {16'd0, ra} * {16'd0, rb});
      wait_done("rand", 1'b0);
      after_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
